// File: rtl/gen1_scr_pkg.sv
// Shared constants, LFSR step function and lock FSM state type for the
// PCIe Gen1 receive descrambler.
package gen1_scr_pkg;

    localparam int unsigned LFSR_W = 16;

    localparam logic [7:0]        COM_SYM   = 8'hBC;
    localparam logic [7:0]        SKP_SYM   = 8'h1C;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hFFFF;

    // x^16 + x^5 + x^4 + x^3 + 1 in Galois form: feedback into bits 3, 4 and 5.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h0038;

    localparam logic [1:0] ADV_ONE     = 2'b00;
    localparam logic [1:0] ADV_TWO     = 2'b01;
    localparam logic [1:0] ADV_FOUR    = 2'b10;
    localparam logic [1:0] ADV_ILLEGAL = 2'b11;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[LFSR_W-1]} ^ (s[LFSR_W-1] ? LFSR_TAPS : '0);
    endfunction

endpackage

// File: rtl/gen1_descr_lfsr8.sv
// One-symbol descrambler step: produces the output byte and the LFSR state
// seen by the next symbol of the beat.
module gen1_descr_lfsr8
    import gen1_scr_pkg::*;
(
    input  logic [7:0]        data_i,
    input  logic              k_i,
    input  logic              ts_i,
    input  logic              en_i,
    input  logic [LFSR_W-1:0] lfsr_i,
    output logic [7:0]        data_o,
    output logic [LFSR_W-1:0] lfsr_o
);

    logic [7:0]        scr_byte;
    logic [LFSR_W-1:0] lfsr_adv;

    always_comb begin
        scr_byte = '0;
        lfsr_adv = lfsr_i;
        for (int unsigned j = 0; j < 8; j++) begin
            scr_byte[j] = lfsr_adv[LFSR_W-1];
            lfsr_adv    = lfsr_step(lfsr_adv);
        end
    end

    always_comb begin
        data_o = data_i;
        lfsr_o = lfsr_adv;
        if (k_i) begin
            if (data_i == COM_SYM) begin
                lfsr_o = LFSR_SEED;
            end else if (data_i == SKP_SYM) begin
                lfsr_o = lfsr_i;
            end
        end else if (!ts_i && en_i) begin
            data_o = data_i ^ scr_byte;
        end
    end

endmodule

// File: rtl/gen1_descrambler.sv
// PCIe Gen1 receive descrambler: 4-lane symbol chain, COM-synchronised LFSR,
// lock timeout FSM. Optional lock-loss counter: GEN1_DESCR_LOCK_LOSS_CNT_EN.
module gen1_descrambler
    import gen1_scr_pkg::*;
#(
    parameter int unsigned LOCK_TIMEOUT = 1024,
    parameter int unsigned CNT_W        = 11
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [3:0]  datak_i,
    input  logic [3:0]  training_sequence_i,
    input  logic [1:0]  data_len_i,
    input  logic [31:0] indata_i,
    input  logic        scramble_enable_i,
    output logic        valid_o,
    output logic [3:0]  datak_o,
    output logic [1:0]  data_len_o,
    output logic [31:0] descrambled_data_o,
    output logic        locked_o
`ifdef GEN1_DESCR_LOCK_LOSS_CNT_EN
    ,
    output logic [7:0]  lock_loss_cnt_o
`endif
);

    lock_state_e       state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;
    logic              valid_q;
    logic [3:0]        datak_q;
    logic [1:0]        len_q;
    logic [31:0]       data_q;
    logic [31:0]       data_d;
    logic              locked_q;

    logic        legal;
    logic [3:0]  act;
    logic [3:0]  com_lane;
    logic        has_com;
    logic        lock_drop;
    logic [3:0]  lane_en;
    logic [7:0]  lane_out0, lane_out1, lane_out2, lane_out3;
    logic [LFSR_W-1:0] lfsr_1, lfsr_2, lfsr_3, lfsr_4;

    assign legal = valid_i && (data_len_i != ADV_ILLEGAL);

    always_comb begin
        act = 4'b0000;
        case (data_len_i)
            ADV_ONE:  act = 4'b0001;
            ADV_TWO:  act = 4'b0011;
            ADV_FOUR: act = 4'b1111;
            default:  act = 4'b0000;
        endcase
    end

    always_comb begin
        com_lane = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            com_lane[i] = act[i] && datak_i[i] && (indata_i[8*i +: 8] == COM_SYM);
        end
    end

    assign has_com = |com_lane;

    // While unlocked, only bytes following a COM earlier in the same beat descramble.
    assign lane_en[0] = scramble_enable_i && (state_q == LOCKED);
    assign lane_en[1] = scramble_enable_i && ((state_q == LOCKED) || com_lane[0]);
    assign lane_en[2] = scramble_enable_i && ((state_q == LOCKED) || (|com_lane[1:0]));
    assign lane_en[3] = scramble_enable_i && ((state_q == LOCKED) || (|com_lane[2:0]));

    gen1_descr_lfsr8 u_lane0 (
        .data_i (indata_i[7:0]),
        .k_i    (datak_i[0]),
        .ts_i   (training_sequence_i[0]),
        .en_i   (lane_en[0]),
        .lfsr_i (lfsr_q),
        .data_o (lane_out0),
        .lfsr_o (lfsr_1)
    );

    gen1_descr_lfsr8 u_lane1 (
        .data_i (indata_i[15:8]),
        .k_i    (datak_i[1]),
        .ts_i   (training_sequence_i[1]),
        .en_i   (lane_en[1]),
        .lfsr_i (lfsr_1),
        .data_o (lane_out1),
        .lfsr_o (lfsr_2)
    );

    gen1_descr_lfsr8 u_lane2 (
        .data_i (indata_i[23:16]),
        .k_i    (datak_i[2]),
        .ts_i   (training_sequence_i[2]),
        .en_i   (lane_en[2]),
        .lfsr_i (lfsr_2),
        .data_o (lane_out2),
        .lfsr_o (lfsr_3)
    );

    gen1_descr_lfsr8 u_lane3 (
        .data_i (indata_i[31:24]),
        .k_i    (datak_i[3]),
        .ts_i   (training_sequence_i[3]),
        .en_i   (lane_en[3]),
        .lfsr_i (lfsr_3),
        .data_o (lane_out3),
        .lfsr_o (lfsr_4)
    );

    always_comb begin
        case (data_len_i)
            ADV_ONE: lfsr_d = lfsr_1;
            ADV_TWO: lfsr_d = lfsr_2;
            default: lfsr_d = lfsr_4;
        endcase
    end

    assign data_d = {lane_out3 & {8{act[3]}},
                     lane_out2 & {8{act[2]}},
                     lane_out1 & {8{act[1]}},
                     lane_out0 & {8{act[0]}}};

    assign lock_drop = legal && (state_q == LOCKED) && !has_com &&
                       (cnt_q == CNT_W'(LOCK_TIMEOUT - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= UNLOCKED;
            cnt_q    <= '0;
            lfsr_q   <= LFSR_SEED;
            valid_q  <= 1'b0;
            datak_q  <= '0;
            len_q    <= '0;
            data_q   <= '0;
            locked_q <= 1'b0;
        end else begin
            valid_q <= legal;
            if (legal) begin
                datak_q <= datak_i;
                len_q   <= data_len_i;
                data_q  <= data_d;
                lfsr_q  <= lfsr_d;
                // locked_o reflects the state after this beat, so it drops on
                // the timeout beat even though that beat is still descrambled.
                case (state_q)
                    UNLOCKED: begin
                        if (has_com) begin
                            state_q  <= LOCKED;
                            cnt_q    <= '0;
                            locked_q <= 1'b1;
                        end else begin
                            locked_q <= 1'b0;
                        end
                    end
                    LOCKED: begin
                        if (has_com) begin
                            cnt_q    <= '0;
                            locked_q <= 1'b1;
                        end else if (lock_drop) begin
                            state_q  <= UNLOCKED;
                            cnt_q    <= '0;
                            locked_q <= 1'b0;
                        end else begin
                            cnt_q    <= cnt_q + 1'b1;
                            locked_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q  <= UNLOCKED;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef GEN1_DESCR_LOCK_LOSS_CNT_EN
    logic [7:0] loss_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            loss_q <= '0;
        end else if (lock_drop && (loss_q != 8'hFF)) begin
            loss_q <= loss_q + 8'd1;
        end
    end

    assign lock_loss_cnt_o = loss_q;
`endif

    assign valid_o            = valid_q;
    assign datak_o            = datak_q;
    assign data_len_o         = len_q;
    assign descrambled_data_o = data_q;
    assign locked_o           = locked_q;

endmodule

// File: tb/tb_gen1_descrambler.sv
// Scoreboard bench for gen1_descrambler: directed beats push expected results,
// a negedge monitor pops and compares whenever valid_o is high.
module tb_gen1_descrambler;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [3:0]  datak_i;
    logic [3:0]  training_sequence_i;
    logic [1:0]  data_len_i;
    logic [31:0] indata_i;
    logic        scramble_enable_i;
    logic        valid_o;
    logic [3:0]  datak_o;
    logic [1:0]  data_len_o;
    logic [31:0] descrambled_data_o;
    logic        locked_o;
`ifdef GEN1_DESCR_LOCK_LOSS_CNT_EN
    logic [7:0]  lock_loss_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    gen1_descrambler #(
        .LOCK_TIMEOUT (1024),
        .CNT_W        (11)
    ) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .valid_i             (valid_i),
        .datak_i             (datak_i),
        .training_sequence_i (training_sequence_i),
        .data_len_i          (data_len_i),
        .indata_i            (indata_i),
        .scramble_enable_i   (scramble_enable_i),
        .valid_o             (valid_o),
        .datak_o             (datak_o),
        .data_len_o          (data_len_o),
        .descrambled_data_o  (descrambled_data_o),
        .locked_o            (locked_o)
`ifdef GEN1_DESCR_LOCK_LOSS_CNT_EN
        ,
        .lock_loss_cnt_o     (lock_loss_cnt_o)
`endif
    );

    typedef struct packed {
        logic [3:0]  k;
        logic [1:0]  len;
        logic [31:0] d;
        logic        lk;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic send(input logic [3:0] k, input logic [3:0] ts, input logic [1:0] len,
                        input logic [31:0] d, input logic en,
                        input logic [31:0] exp_d, input logic exp_lk);
        exp_t e;
        valid_i             = 1'b1;
        datak_i             = k;
        training_sequence_i = ts;
        data_len_i          = len;
        indata_i            = d;
        scramble_enable_i   = en;
        if (len != 2'b11) begin
            e.k  = k;
            e.len = len;
            e.d  = exp_d;
            e.lk = exp_lk;
            sb_q.push_back(e);
        end
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (valid_o === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL spurious_valid: valid_o=1 with no beat outstanding, required 0");
                end else begin
                    e = sb_q.pop_front();
                    check("data",   descrambled_data_o, e.d);
                    check("datak",  {28'b0, datak_o},   {28'b0, e.k});
                    check("len",    {30'b0, data_len_o}, {30'b0, e.len});
                    check("locked", {31'b0, locked_o},  {31'b0, e.lk});
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned w;
        rst_i = 1'b1;
        valid_i = 1'b0; datak_i = '0; training_sequence_i = '0;
        data_len_i = '0; indata_i = '0; scramble_enable_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_valid_o",  {31'b0, valid_o},    32'h0);
        check("rst_datak_o",  {28'b0, datak_o},    32'h0);
        check("rst_len_o",    {30'b0, data_len_o}, 32'h0);
        check("rst_data_o",   descrambled_data_o,  32'h0);
        check("rst_locked_o", {31'b0, locked_o},   32'h0);
        rst_i = 1'b0;
        idle(1);

        // Unlocked pass-through, then COM in lane 0 locks and descrambles lanes 1-3.
        send(4'b0000, 4'b0000, 2'b00, 32'h0000005A, 1'b1, 32'h0000005A, 1'b0);
        send(4'b0001, 4'b0000, 2'b10, 32'hC017FFBC, 1'b1, 32'h000000BC, 1'b1);
        idle(3);
        send(4'b0000, 4'b0000, 2'b10, 32'h02E7B214, 1'b1, 32'h00000000, 1'b1);

        // Same stream in 1- and 2-byte beats; unused upper bytes forced to 0.
        send(4'b0001, 4'b0000, 2'b00, 32'hAAAAAABC, 1'b1, 32'h000000BC, 1'b1);
        send(4'b0000, 4'b0000, 2'b01, 32'h555517FF, 1'b1, 32'h00000000, 1'b1);
        send(4'b0000, 4'b0000, 2'b01, 32'h000014C0, 1'b1, 32'h00000000, 1'b1);
        send(4'b0000, 4'b0000, 2'b00, 32'h000000B2, 1'b1, 32'h00000000, 1'b1);
        send(4'b0000, 4'b0000, 2'b00, 32'h000000E7, 1'b1, 32'h00000000, 1'b1);
        send(4'b0000, 4'b0000, 2'b01, 32'h00008202, 1'b1, 32'h00000000, 1'b1);

        // SKP does not advance; last of two COMs seeds the following bytes.
        send(4'b0001, 4'b0000, 2'b00, 32'h000000BC, 1'b1, 32'h000000BC, 1'b1);
        send(4'b0001, 4'b0000, 2'b10, 32'hC017FF1C, 1'b1, 32'h0000001C, 1'b1);
        send(4'b0110, 4'b0000, 2'b10, 32'hFFBCBC55, 1'b1, 32'h00BCBC41, 1'b1);
        send(4'b0000, 4'b0000, 2'b00, 32'h00000017, 1'b1, 32'h00000000, 1'b1);

        // Training-sequence bytes pass raw but advance the LFSR.
        send(4'b0001, 4'b1110, 2'b10, 32'h4A4A4ABC, 1'b1, 32'h4A4A4ABC, 1'b1);
        send(4'b0000, 4'b0000, 2'b10, 32'h02E7B214, 1'b1, 32'h00000000, 1'b1);

        // Scrambling disabled: raw output, LFSR keeps tracking.
        send(4'b0001, 4'b0000, 2'b00, 32'h000000BC, 1'b1, 32'h000000BC, 1'b1);
        send(4'b0000, 4'b0000, 2'b01, 32'h000017FF, 1'b0, 32'h000017FF, 1'b1);
        send(4'b0000, 4'b0000, 2'b01, 32'h000014C0, 1'b1, 32'h00000000, 1'b1);

        // Illegal beats leave no trace, even one carrying a COM.
        send(4'b0001, 4'b0000, 2'b00, 32'h000000BC, 1'b1, 32'h000000BC, 1'b1);
        send(4'b0000, 4'b0000, 2'b11, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b0);
        check("illegal_valid_o", {31'b0, valid_o}, 32'h0);
        send(4'b0000, 4'b0000, 2'b10, 32'h14C017FF, 1'b1, 32'h00000000, 1'b1);
        send(4'b0001, 4'b0000, 2'b00, 32'h000000BC, 1'b1, 32'h000000BC, 1'b1);
        send(4'b0000, 4'b0000, 2'b01, 32'h000017FF, 1'b1, 32'h00000000, 1'b1);
        send(4'b0001, 4'b0000, 2'b11, 32'h000000BC, 1'b1, 32'h0, 1'b0);
        check("illegal_com_valid_o", {31'b0, valid_o}, 32'h0);
        send(4'b0000, 4'b0000, 2'b01, 32'h000014C0, 1'b1, 32'h00000000, 1'b1);

        // Lock timeout: locked_o falls on the 1024th COM-free beat.
        send(4'b0001, 4'b0000, 2'b00, 32'h000000BC, 1'b1, 32'h000000BC, 1'b1);
        for (int i = 1; i <= 1023; i++) begin
            send(4'b0000, 4'b0001, 2'b00, 32'h0000004A, 1'b1, 32'h0000004A, 1'b1);
        end
        send(4'b0000, 4'b0001, 2'b00, 32'h0000004A, 1'b1, 32'h0000004A, 1'b0);
        send(4'b0000, 4'b0000, 2'b00, 32'h00000033, 1'b1, 32'h00000033, 1'b0);
        send(4'b0001, 4'b0000, 2'b10, 32'hC017FFBC, 1'b1, 32'h000000BC, 1'b1);

        // Asynchronous reset in the middle of a beat.
        idle(1);
        valid_i = 1'b1; datak_i = 4'b0001; training_sequence_i = '0;
        data_len_i = 2'b10; indata_i = 32'hC017FFBC; scramble_enable_i = 1'b1;
        #2;
        rst_i = 1'b1;
        #1;
        check("midrst_valid_o",  {31'b0, valid_o},    32'h0);
        check("midrst_datak_o",  {28'b0, datak_o},    32'h0);
        check("midrst_len_o",    {30'b0, data_len_o}, 32'h0);
        check("midrst_data_o",   descrambled_data_o,  32'h0);
        check("midrst_locked_o", {31'b0, locked_o},   32'h0);
        valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        send(4'b0000, 4'b0000, 2'b10, 32'hC017FFBC, 1'b1, 32'hC017FFBC, 1'b0);
        send(4'b0100, 4'b0000, 2'b10, 32'hFFBC1234, 1'b1, 32'h00BC1234, 1'b1);

        w = 0;
        while (sb_q.size() != 0 && w < 20) begin
            @(posedge clk_i);
            w++;
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d beats still outstanding, required 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gen1_descrambler.md
Name: gen1_descrambler

Overview:
Receive-side PCIe Gen1 descrambler. It takes up to 4 received 8b symbols per cycle and removes the x^16+x^5+x^4+x^3+1 scrambling applied by the transmitter. Its LFSR is synchronised by COM symbols, and lock is tracked with a timeout state machine. It sits between the 8b/10b decoder and the ordered-set/packet parser, with a registered, 1-cycle-latency output.

Parameters:
LOCK_TIMEOUT, 1024, number of consecutive valid beats without a COM before lock is dropped (min 2).
CNT_W, 11, width of the timeout counter; must satisfy 2^CNT_W > LOCK_TIMEOUT.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-high
valid_i  in  1  input beat valid
datak_i  in  4  per-byte K-symbol flag; bit i corresponds to byte i
training_sequence_i  in  4  per-byte flag: byte is a TS1/TS2 payload byte, never scrambled
data_len_i  in  2  00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes, 11 = illegal
indata_i  in  32  received symbols; byte 0 = [7:0] is first in time
scramble_enable_i  in  1  0 = descrambling bypassed (link-disabled scrambling)
valid_o  out  1  output beat valid
datak_o  out  4  registered datak_i
data_len_o  out  2  registered data_len_i
descrambled_data_o  out  32  descrambled bytes; unused upper bytes forced to 0
locked_o  out  1  LFSR synchronised to the received stream

Behaviour:
- Reset values: valid_o=0, datak_o=0, data_len_o=0, descrambled_data_o=0, locked_o=0, LFSR=16'hFFFF, timeout counter=0, FSM=UNLOCKED.
- Latency: exactly 1 clock from valid_i to valid_o. There is no backpressure.
- Active bytes: byte i is active iff i < N, where N = 1, 2 or 4 from data_len_i.
- Illegal beat (data_len_i=11 with valid_i=1): valid_o=0 on the next cycle; LFSR, counter and FSM are unchanged.
- Per-byte chain, evaluated in order byte 0..N-1. Each byte sees the LFSR state left by the previous byte:
  - K and byte==8'hBC (COM): output the byte unchanged; the next byte's LFSR state = 16'hFFFF.
  - K and byte==8'h1C (SKP): output the byte unchanged; LFSR not advanced.
  - any other K: output the byte unchanged; LFSR advanced 8 steps.
  - D with training_sequence_i[i]=1: output the byte unchanged; LFSR advanced 8 steps.
  - any other D: output = byte XOR scramble byte; LFSR advanced 8 steps.
- Scramble byte: bit j (j=0..7) = LFSR[15] before step j. One step shifts left with taps feeding bits 3, 4 and 5 from bit 15 (Galois form), bit 0 = old bit 15.
- scramble_enable_i=0: all bytes pass through unchanged. LFSR, FSM and counter still update per the rules above, so sync survives a toggle.
- Global LFSR register is loaded with the chain output after byte N-1 on every legal valid beat. It holds when valid_i=0.
- FSM UNLOCKED: all bytes pass through unchanged and locked_o=0. On any legal beat containing an active COM → LOCKED, with counter cleared. Bytes after the COM in the same beat are descrambled.
- FSM LOCKED: descramble per the chain and set locked_o=1.
  - A legal beat containing an active COM clears the counter.
  - Otherwise the counter increments.
  - Counter reaching LOCK_TIMEOUT → UNLOCKED; that beat is still descrambled.
- locked_o is registered and aligned with valid_o of the same beat. It rises on the beat containing the COM.
- Multiple COMs in one beat: the last COM sets the seed for the bytes after it.
- Reset mid-stream returns every state to its reset value; the first output after reset is unlocked pass-through.

Optional Feature:
GEN1_DESCR_LOCK_LOSS_CNT_EN
- Defined: adds output port lock_loss_cnt_o [7:0]. It is a saturating count of LOCKED→UNLOCKED transitions, holds at 8'hFF, and resets to 0.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Package gen1_scr_pkg holds:
  - COM_SYM=8'hBC, SKP_SYM=8'h1C, LFSR_SEED=16'hFFFF
  - data_len encodings ADV_ONE/ADV_TWO/ADV_FOUR
  - LFSR width 16 and the tap mask
  - FSM state enum UNLOCKED/LOCKED
- Sub-module gen1_descr_lfsr8: combinational one-byte step. Inputs: byte, K flag, TS flag, enable, lfsr_in. Outputs: out byte, lfsr_out. Instantiated 4 times in a chain.
- Top level contains the registers, the FSM and the counter.

Test Plan:
1. Reset, then beat {D 8'hC0, D 8'h17, D 8'hFF, K 8'hBC} (byte 0 = COM), len=10 → next cycle out bytes [0..3] = BC,00,00,00, locked_o=1, valid_o=1.
2. Locked, following beat of scrambled bytes 14,B2,E7,02 (len=10) → out 00,00,00,00. Same stream split into len=00/01 beats yields identical bytes.
3. Locked, beat with SKP K 8'h1C in lane 0 and scrambled data in lanes 1-3 → SKP passes through, lanes 1-3 still descramble to 00 (LFSR not advanced by SKP).
4. Locked, then 1024 valid beats without COM → locked_o falls on beat 1024. Beat 1025 passes through raw. A subsequent COM relocks.
5. training_sequence_i=4'b1110 with data 4A,4A,4A after COM → the 4A bytes pass through unchanged while the LFSR still advances; next beat descrambles correctly.
6. data_len_i=11 with valid_i=1 → valid_o=0 and the following legal beat descrambles as if the illegal beat was absent. Assert rst_i mid-beat → all outputs 0 and locked_o=0.
